// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller with interrupts:
// opcodes, FSM states, pc_source codes and the ctrl bundle layout.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RFE   = 6'b010000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_WB = 3'd3,
    S_MEM_RD = 3'd4,
    S_IRQ    = 3'd5
  } state_t;

  localparam logic [2:0] PCS_SEQ = 3'b000;
  localparam logic [2:0] PCS_BR  = 3'b001;
  localparam logic [2:0] PCS_JMP = 3'b010;
  localparam logic [2:0] PCS_IRQ = 3'b011;
  localparam logic [2:0] PCS_EPC = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] WDST_RT = 2'b00;
  localparam logic [1:0] WDST_RD = 2'b01;
  localparam logic [1:0] WDST_RA = 2'b10;

  localparam logic [1:0] WDAT_ALU = 2'b00;
  localparam logic [1:0] WDAT_MEM = 2'b01;
  localparam logic [1:0] WDAT_PC  = 2'b10;

  // ctrl bit offsets, LSB first
  localparam int CF_MMIO_LOAD     = 0;
  localparam int CF_IMM_COM       = 1;
  localparam int CF_PC_WRITE_COND = 2;
  localparam int CF_PC_WRITE      = 3;
  localparam int CF_IR_WRITE      = 4;
  localparam int CF_REG_WRITE     = 5;
  localparam int CF_I_OR_D        = 6;
  localparam int CF_MEM_WRITE     = 7;
  localparam int CF_MEM_READ      = 8;
  localparam int CF_PC_SOURCE     = 9;
  localparam int CF_WREG_DATA_SEL = 12;
  localparam int CF_WREG_DST      = 14;
  localparam int CF_ALU_SRC_B     = 16;
  localparam int CF_ALU_SRC_A     = 18;
  localparam int CF_ALU_OP        = 19;
  localparam int CTRL_W           = 21;

  function automatic logic is_itype(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/mc_ctrl_irq_if.sv
// Controller <-> datapath/peripheral signal bundle.
// master: controller side; slave: datapath side.
interface mc_ctrl_irq_if #(
  parameter int NUM_IRQ  = 4,
  parameter int NUM_MMIO = 2
);
  import ctrl_pkg::*;

  logic [5:0]          opcode;
  logic [31:0]         alu_out;
  logic [NUM_IRQ-1:0]  irq;
  logic [CTRL_W-1:0]   ctrl;
  logic                int_save_pc;
  logic [NUM_IRQ-1:0]  irq_ack;
  logic [2:0]          irq_id;
  logic [NUM_MMIO-1:0] mmio_rd;
  logic [NUM_MMIO-1:0] mmio_wr;
  logic [NUM_MMIO-1:0] mmio_rd_end;

  modport master (
    input  opcode, alu_out, irq,
    output ctrl, int_save_pc, irq_ack, irq_id,
    output mmio_rd, mmio_wr, mmio_rd_end
  );

  modport slave (
    output opcode, alu_out, irq,
    input  ctrl, int_save_pc, irq_ack, irq_id,
    input  mmio_rd, mmio_wr, mmio_rd_end
  );

endinterface

// File: rtl/irq_pend.sv
// Interrupt edge detect, pending latch and lowest-index priority pick.
// A new edge on the source being acknowledged keeps it pending.
module irq_pend #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               ack_i,
  output logic               any_o,
  output logic [2:0]         id_o,
  output logic [NUM_IRQ-1:0] oh_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;

  always_comb begin
    id_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) id_o = 3'(i);
    end
    any_o = |pend_q;
    oh_o  = any_o ? (NUM_IRQ'(1) << id_o) : '0;
  end

  always_comb begin
    pend_d = pend_q;
    if (ack_i) pend_d = pend_d & ~oh_o;
    pend_d = pend_d | (irq_i & ~irq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_irq.sv
// Multicycle controller FSM with vectored interrupt entry/return.
// Define CTRL_MMIO_EN to decode LW/SW addresses onto MMIO strobes.
module mc_ctrl_irq #(
  parameter int NUM_IRQ  = 4,
  parameter int NUM_MMIO = 2,
  parameter logic [32*NUM_MMIO-1:0] MMIO_ADDRS =
    {32'h0000_01EC, 32'h0000_0204}
) (
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_irq_if.master bus
);
  import ctrl_pkg::*;

  state_t state_q, state_d;
  logic   inten_q, inten_d;
  logic   hit_q, hit_d;
  logic [1:0] sel_q, sel_d;

  logic       mm_hit;
  logic [1:0] mm_sel;
  logic       pend_any;
  logic [2:0] pend_id;
  logic [NUM_IRQ-1:0] pend_oh;
  logic       ack_en;
  logic [CTRL_W-1:0] c;

  logic op_lw, op_sw, op_r, op_i;
  logic op_beq, op_j, op_jal, op_rfe;

  irq_pend #(.NUM_IRQ(NUM_IRQ)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .irq_i (bus.irq),
    .ack_i (ack_en),
    .any_o (pend_any),
    .id_o  (pend_id),
    .oh_o  (pend_oh)
  );

  assign op_lw  = bus.opcode == OP_LW;
  assign op_sw  = bus.opcode == OP_SW;
  assign op_r   = bus.opcode == OP_RTYPE;
  assign op_i   = is_itype(bus.opcode);
  assign op_beq = bus.opcode == OP_BEQ;
  assign op_j   = bus.opcode == OP_J;
  assign op_jal = bus.opcode == OP_JAL;
  assign op_rfe = bus.opcode == OP_RFE;

`ifdef CTRL_MMIO_EN
  // descending scan so the lowest matching slot wins
  always_comb begin
    mm_hit = 1'b0;
    mm_sel = '0;
    for (int k = NUM_MMIO - 1; k >= 0; k--) begin
      if (bus.alu_out == MMIO_ADDRS[32*k +: 32]) begin
        mm_hit = 1'b1;
        mm_sel = 2'(k);
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MMIO_ADDRS, bus.alu_out};
  assign mm_hit = 1'b0;
  assign mm_sel = '0;
`endif

  always_comb begin
    state_d         = state_q;
    inten_d         = inten_q;
    hit_d           = hit_q;
    sel_d           = sel_q;
    c               = '0;
    ack_en          = 1'b0;
    bus.int_save_pc = 1'b0;
    bus.mmio_rd     = '0;
    bus.mmio_wr     = '0;
    bus.mmio_rd_end = '0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          if (inten_q && pend_any) begin
            bus.int_save_pc = 1'b1;
            state_d         = S_IRQ;
          end else begin
            c[CF_MEM_READ]          = 1'b1;
            c[CF_IR_WRITE]          = 1'b1;
            c[CF_PC_WRITE]          = 1'b1;
            c[CF_ALU_SRC_B +: 2]    = SRCB_FOUR;
            c[CF_ALU_OP +: 2]       = ALU_ADD;
            c[CF_PC_SOURCE +: 3]    = PCS_SEQ;
            state_d                 = S_DECODE;
          end
        end
        S_DECODE: begin
          c[CF_ALU_SRC_B +: 2] = SRCB_BR;
          state_d              = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          unique case (1'b1)
            op_lw, op_sw: begin
              c[CF_ALU_SRC_A]      = 1'b1;
              c[CF_ALU_SRC_B +: 2] = SRCB_IMM;
              state_d              = S_MEM_WB;
            end
            op_r: begin
              c[CF_ALU_SRC_A]      = 1'b1;
              c[CF_ALU_SRC_B +: 2] = SRCB_REG;
              c[CF_ALU_OP +: 2]    = ALU_FUNCT;
              state_d              = S_MEM_WB;
            end
            op_i: begin
              c[CF_ALU_SRC_A]      = 1'b1;
              c[CF_ALU_SRC_B +: 2] = SRCB_IMM;
              c[CF_ALU_OP +: 2]    = ALU_IMM;
              c[CF_IMM_COM]        = 1'b1;
              state_d              = S_MEM_WB;
            end
            op_beq: begin
              c[CF_ALU_SRC_A]      = 1'b1;
              c[CF_ALU_OP +: 2]    = ALU_SUB;
              c[CF_PC_WRITE_COND]  = 1'b1;
              c[CF_PC_SOURCE +: 3] = PCS_BR;
            end
            op_j: begin
              c[CF_PC_WRITE]       = 1'b1;
              c[CF_PC_SOURCE +: 3] = PCS_JMP;
            end
            op_jal: begin
              c[CF_PC_WRITE]           = 1'b1;
              c[CF_PC_SOURCE +: 3]     = PCS_JMP;
              c[CF_REG_WRITE]          = 1'b1;
              c[CF_WREG_DST +: 2]      = WDST_RA;
              c[CF_WREG_DATA_SEL +: 2] = WDAT_PC;
            end
            op_rfe: begin
              c[CF_PC_WRITE]       = 1'b1;
              c[CF_PC_SOURCE +: 3] = PCS_EPC;
              inten_d              = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM_WB: begin
          state_d = S_FETCH;
          unique case (1'b1)
            op_lw: begin
              hit_d   = mm_hit;
              sel_d   = mm_sel;
              state_d = S_MEM_RD;
              if (mm_hit) begin
                c[CF_MMIO_LOAD] = 1'b1;
                bus.mmio_rd     = NUM_MMIO'(1) << mm_sel;
              end else begin
                c[CF_MEM_READ] = 1'b1;
                c[CF_I_OR_D]   = 1'b1;
              end
            end
            op_sw: begin
              if (mm_hit) begin
                bus.mmio_wr = NUM_MMIO'(1) << mm_sel;
              end else begin
                c[CF_MEM_WRITE] = 1'b1;
                c[CF_I_OR_D]    = 1'b1;
              end
            end
            op_r: begin
              c[CF_REG_WRITE]          = 1'b1;
              c[CF_WREG_DST +: 2]      = WDST_RD;
              c[CF_WREG_DATA_SEL +: 2] = WDAT_ALU;
            end
            op_i: begin
              c[CF_REG_WRITE]     = 1'b1;
              c[CF_WREG_DST +: 2] = WDST_RT;
            end
            default: ;
          endcase
        end
        S_MEM_RD: begin
          c[CF_REG_WRITE]          = 1'b1;
          c[CF_WREG_DATA_SEL +: 2] = WDAT_MEM;
          if (hit_q) bus.mmio_rd_end = NUM_MMIO'(1) << sel_q;
          hit_d   = 1'b0;
          state_d = S_FETCH;
        end
        S_IRQ: begin
          c[CF_PC_WRITE]       = 1'b1;
          c[CF_PC_SOURCE +: 3] = PCS_IRQ;
          ack_en               = 1'b1;
          inten_d              = 1'b0;
          state_d              = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.ctrl    = c;
  assign bus.irq_ack = ack_en ? pend_oh : '0;
  assign bus.irq_id  = ack_en ? pend_id : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      inten_q <= 1'b1;
      hit_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      inten_q <= inten_d;
      hit_q   <= hit_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_irq.sv
// Randomized bench for mc_ctrl_irq against an instruction-level model
// of cycle counts, interrupt pending/priority and MMIO decode.
module tb_mc_ctrl_irq;
  import ctrl_pkg::*;

  localparam int NI = 4;
  localparam int NM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_ctrl_irq_if #(.NUM_IRQ(NI), .NUM_MMIO(NM)) bus();

  mc_ctrl_irq #(
    .NUM_IRQ    (NI),
    .NUM_MMIO   (NM),
    .MMIO_ADDRS ({32'h0000_01EC, 32'h0000_0204})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NI-1:0] m_pend;
  logic [NI-1:0] m_prev;
  logic          m_inten;
  logic          rand_irq;
  int            obs_ids[$];

  logic [31:0] slot_addr [NM] = '{32'h0000_0204, 32'h0000_01EC};
  logic [5:0]  ops [11] = '{OP_LW, OP_SW, OP_RTYPE, 6'h08, 6'h0D,
                            OP_BEQ, OP_J, OP_JAL, OP_RFE, 6'h01, 6'h3F};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input int off, input int w);
    logic [31:0] v;
    v = 32'(bus.ctrl) >> off;
    return v & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int mm_slot(input logic [31:0] a);
`ifdef CTRL_MMIO_EN
    for (int k = 0; k < NM; k++) if (a == slot_addr[k]) return k;
`endif
    return -1;
  endfunction

  function automatic int ncyc(input logic [5:0] op);
    case (op)
      OP_LW:                           return 5;
      OP_SW, OP_RTYPE, 6'h08, 6'h0D:   return 4;
      default:                         return 3;
    endcase
  endfunction

  function automatic int lowest(input logic [NI-1:0] p);
    for (int i = 0; i < NI; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic step(input logic [NI-1:0] clr);
    @(posedge clk);
    m_pend = (m_pend & ~clr) | (bus.irq & ~m_prev);
    m_prev = bus.irq;
    @(negedge clk);
    if (rand_irq)
      for (int i = 0; i < NI; i++)
        if ($urandom_range(7) == 0) bus.irq[i] = ~bus.irq[i];
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.irq = '0;
    #1;
    chk("rst_ctrl", 32'(bus.ctrl), 0);
    chk("rst_save", 32'(bus.int_save_pc), 0);
    chk("rst_ack", 32'(bus.irq_ack), 0);
    chk("rst_id", 32'(bus.irq_id), 0);
    chk("rst_mmio", {bus.mmio_rd, bus.mmio_wr, bus.mmio_rd_end}, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pend = '0;
    m_prev = '0;
    m_inten = 1'b1;
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [31:0] addr,
                           input int set_ph, input logic [NI-1:0] set_v,
                           input int abort_ph);
    int n, id, slot;
    bus.opcode  = op;
    bus.alu_out = addr;
    if (m_inten && m_pend != '0) begin
      chk("ent_save", 32'(bus.int_save_pc), 1);
      chk("ent_irw", fld(CF_IR_WRITE, 1), 0);
      chk("ent_mrd", fld(CF_MEM_READ, 1), 0);
      chk("ent_pcw", fld(CF_PC_WRITE, 1), 0);
      step('0);
      id = lowest(m_pend);
      chk("irq_pcw", fld(CF_PC_WRITE, 1), 1);
      chk("irq_pcs", fld(CF_PC_SOURCE, 3), 32'b011);
      chk("irq_id", 32'(bus.irq_id), id);
      chk("irq_ack", 32'(bus.irq_ack), 32'd1 << id);
      chk("irq_save", 32'(bus.int_save_pc), 0);
      obs_ids.push_back(int'(bus.irq_id));
      m_inten = 1'b0;
      step(NI'(1) << id);
    end
    slot = mm_slot(addr);
    n = ncyc(op);
    for (int p = 0; p < n; p++) begin
      if (p == abort_ph) begin
        do_reset();
        return;
      end
      if (p == set_ph) bus.irq = set_v;
      if (p == 4) bus.alu_out = $urandom;
      chk("ack_idle", 32'(bus.irq_ack), 0);
      chk("save_idle", 32'(bus.int_save_pc), 0);
      case (p)
        0: begin
          chk("f_irw", fld(CF_IR_WRITE, 1), 1);
          chk("f_mrd", fld(CF_MEM_READ, 1), 1);
          chk("f_pcw", fld(CF_PC_WRITE, 1), 1);
          chk("f_pcs", fld(CF_PC_SOURCE, 3), 0);
        end
        1: begin
          chk("d_irw", fld(CF_IR_WRITE, 1), 0);
          chk("d_pcw", fld(CF_PC_WRITE, 1), 0);
          chk("d_rw", fld(CF_REG_WRITE, 1), 0);
          chk("d_mem", fld(CF_MEM_READ, 2), 0);
        end
        2: begin
          case (op)
            OP_BEQ: begin
              chk("beq_alu", fld(CF_ALU_OP, 2), 1);
              chk("beq_cond", fld(CF_PC_WRITE_COND, 1), 1);
              chk("beq_pcs", fld(CF_PC_SOURCE, 3), 1);
              chk("beq_pcw", fld(CF_PC_WRITE, 1), 0);
            end
            OP_J: begin
              chk("j_pcw", fld(CF_PC_WRITE, 1), 1);
              chk("j_pcs", fld(CF_PC_SOURCE, 3), 2);
              chk("j_rw", fld(CF_REG_WRITE, 1), 0);
            end
            OP_JAL: begin
              chk("jal_pcw", fld(CF_PC_WRITE, 1), 1);
              chk("jal_pcs", fld(CF_PC_SOURCE, 3), 2);
              chk("jal_rw", fld(CF_REG_WRITE, 1), 1);
              chk("jal_dst", fld(CF_WREG_DST, 2), 2);
              chk("jal_dat", fld(CF_WREG_DATA_SEL, 2), 2);
            end
            OP_RFE: begin
              chk("rfe_pcw", fld(CF_PC_WRITE, 1), 1);
              chk("rfe_pcs", fld(CF_PC_SOURCE, 3), 3'b100);
            end
            OP_LW, OP_SW, OP_RTYPE, 6'h08, 6'h0D: begin
              chk("e_pcw", fld(CF_PC_WRITE, 1), 0);
              chk("e_rw", fld(CF_REG_WRITE, 1), 0);
              chk("e_mem", fld(CF_MEM_READ, 2), 0);
            end
            default: chk("inv_ctrl", 32'(bus.ctrl), 0);
          endcase
        end
        3: begin
          chk("mw_end", 32'(bus.mmio_rd_end), 0);
          if (op == OP_LW && slot >= 0) begin
            chk("lw_mload", fld(CF_MMIO_LOAD, 1), 1);
            chk("lw_mrd", 32'(bus.mmio_rd), 32'd1 << slot);
            chk("lw_mem", fld(CF_MEM_READ, 1), 0);
          end else if (op == OP_LW) begin
            chk("lw_mem", fld(CF_MEM_READ, 1), 1);
            chk("lw_iord", fld(CF_I_OR_D, 1), 1);
            chk("lw_mrd", 32'(bus.mmio_rd), 0);
            chk("lw_mload", fld(CF_MMIO_LOAD, 1), 0);
          end else if (op == OP_SW && slot >= 0) begin
            chk("sw_mwr", 32'(bus.mmio_wr), 32'd1 << slot);
            chk("sw_mem", fld(CF_MEM_WRITE, 1), 0);
            chk("sw_iord", fld(CF_I_OR_D, 1), 0);
          end else if (op == OP_SW) begin
            chk("sw_mem", fld(CF_MEM_WRITE, 1), 1);
            chk("sw_iord", fld(CF_I_OR_D, 1), 1);
            chk("sw_mwr", 32'(bus.mmio_wr), 0);
          end else begin
            chk("wb_rw", fld(CF_REG_WRITE, 1), 1);
            chk("wb_mw", fld(CF_MEM_WRITE, 1), 0);
          end
        end
        default: begin
          chk("mr_rw", fld(CF_REG_WRITE, 1), 1);
          chk("mr_dat", fld(CF_WREG_DATA_SEL, 2), 1);
          chk("mr_end", 32'(bus.mmio_rd_end),
              slot >= 0 ? 32'd1 << slot : 32'd0);
          chk("mr_mrd", 32'(bus.mmio_rd), 0);
        end
      endcase
      step('0);
      if (p == 2 && op == OP_RFE) m_inten = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] a;
    bus.opcode  = '0;
    bus.alu_out = '0;
    bus.irq     = '0;
    rand_irq    = 1'b0;
    do_reset();

    run_instr(OP_LW, 32'h100, -1, '0, -1);
    run_instr(OP_SW, 32'h1EC, -1, '0, -1);
    run_instr(OP_LW, 32'h204, -1, '0, -1);
    run_instr(OP_SW, 32'h300, -1, '0, -1);

    obs_ids.delete();
    run_instr(OP_RTYPE, 32'h0, 1, 4'b0110, -1);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    run_instr(OP_RFE, 32'h0, -1, '0, -1);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    chk("s33_n", obs_ids.size(), 2);
    if (obs_ids.size() == 2) begin
      chk("s33_first", obs_ids[0], 1);
      chk("s33_second", obs_ids[1], 2);
    end
    run_instr(OP_RFE, 32'h0, 0, '0, -1);

    obs_ids.delete();
    run_instr(OP_RTYPE, 32'h0, 0, 4'b0001, -1);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    run_instr(OP_RTYPE, 32'h0, 1, '0, -1);
    run_instr(OP_RFE, 32'h0, -1, '0, -1);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    chk("s34_acks", obs_ids.size(), 1);
    if (obs_ids.size() == 1) chk("s34_id", obs_ids[0], 0);

    obs_ids.delete();
    run_instr(OP_LW, 32'h204, 2, 4'b0100, 4);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    run_instr(OP_RTYPE, 32'h0, -1, '0, -1);
    chk("s35_noack", obs_ids.size(), 0);

    rand_irq = 1'b1;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(3))
        0: a = 32'h204;
        1: a = 32'h1EC;
        2: a = 32'h100;
        default: a = $urandom;
      endcase
      run_instr(ops[$urandom_range(10)], a, -1, '0,
                $urandom_range(39) == 0 ? int'($urandom_range(4)) : -1);
    end
    rand_irq = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_irq.md
MC_CTRL_IRQ -- requirements
Module: mc_ctrl_irq

Interface
REQ-001 Parameter NUM_IRQ, default 4, SHALL set the number of interrupt sources (1..8); source 0 has highest priority.
REQ-002 Parameter NUM_MMIO, default 2, SHALL set the number of memory-mapped peripherals (1..4).
REQ-003 Parameter MMIO_ADDRS, default {32'h0000_01EC, 32'h0000_0204}, SHALL hold NUM_MMIO packed 32-bit word addresses; slot k is bits [32k+31:32k], so 0x204 is slot 0 (UART) and 0x1EC is slot 1 (LEDs).
REQ-004 clk  in  1  single system clock; one clock, all state on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 opcode  in  6  instruction opcode field from the IR.
REQ-007 alu_out  in  32  datapath ALU result, used as the effective address.
REQ-008 irq  in  NUM_IRQ  level interrupt lines, synchronous to clk.
REQ-009 ctrl  out  CTRL_W  packed datapath control bundle: alu_op, alu_src_a/b, wreg_dst, wreg_data_sel, pc_source[2:0], mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write, pc_write_cond, imm_com, mmio_load.
REQ-010 int_save_pc  out  1  EPC capture strobe.
REQ-011 irq_ack  out  NUM_IRQ  one-hot acknowledge pulse.
REQ-012 irq_id  out  3  index of the acknowledged source, valid with irq_ack.
REQ-013 mmio_rd / mmio_wr / mmio_rd_end  out  NUM_MMIO each  per-peripheral read, write and read-complete strobes.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, EXEC, MEM_WB, MEM_RD and IRQ; any unused encoding SHALL go to FETCH.
REQ-015 Every ctrl field not actively required in a state SHALL be driven 0, never x.
REQ-016 Cycle counts SHALL be: LW 5; SW, R-type and I-type 4; BEQ, J, JAL and RFE 3; invalid opcode 3, returning to FETCH with no write.
REQ-017 Datapath encodings SHALL be: FETCH PC+4 with pc_source 000 and ir_write; DECODE branch target; BEQ sub with pc_write_cond and pc_source 001; J/JAL pc_source 010, with JAL writing reg 31 (wreg_dst 10, wreg_data_sel 10).
REQ-018 A rising edge (0 in previous cycle, 1 now) on irq[i] SHALL set pending[i] on that clock edge.
REQ-019 In FETCH with int_en=1 and any pending bit set, the block SHALL assert int_save_pc, suppress ir_write, mem_read and pc_write, and go to IRQ.
REQ-020 The IRQ state SHALL last one cycle: pc_write=1, pc_source=011, irq_id=lowest pending index, irq_ack one-hot on that index, that pending bit cleared, int_en<=0, next state FETCH.
REQ-021 If a new edge arrives on the source being acknowledged in the same cycle, set SHALL win and the bit stays pending.
REQ-022 RFE (opcode 6'b010000) in EXEC SHALL drive pc_write=1 and pc_source=100, set int_en<=1, and return to FETCH.
REQ-023 In MEM_WB, an LW whose alu_out equals slot k SHALL assert mmio_load and mmio_rd[k] with mem_read=0, and SHALL register k.
REQ-024 In MEM_RD for a peripheral load, mmio_rd_end[k] SHALL use the registered k, not a live alu_out compare.
REQ-025 In MEM_WB, an SW whose alu_out equals slot k SHALL assert mmio_wr[k] with mem_write=0 and i_or_d=0.
REQ-026 If alu_out matches several slots, the lowest k SHALL win; with no match, normal memory access (i_or_d=1) SHALL occur.

Reset
REQ-027 On rst, the block SHALL immediately force state=FETCH, pending=0, int_en=1, irq edge history=0, registered k=0, and all outputs 0, including mid-instruction and mid-IRQ; the first rising clk after release SHALL perform FETCH.

Configuration
REQ-028 With CTRL_MMIO_EN defined, REQ-023..026 SHALL apply; without it, mmio_* outputs and mmio_load SHALL be constant 0, MMIO_ADDRS SHALL be ignored, and all LW/SW SHALL access memory.

Structure
REQ-029 Package ctrl_pkg SHALL hold the opcode constants, state encoding, pc_source codes, CTRL_W and the ctrl field offsets.
REQ-030 Sub-module irq_pend SHALL implement the edge detect, pending register and priority encoder; the FSM SHALL reside in mc_ctrl_irq.

Verification
REQ-031 Reset then LW with alu_out=0x100 -> states F,D,E,MW,MR; mem_read in MW; reg_write with wreg_data_sel=01 in MR.
REQ-032 SW with alu_out=0x1EC (MMIO on) -> mmio_wr=2'b10 for one cycle, mem_write=0; with the macro off -> mem_write=1, mmio_wr=0.
REQ-033 irq=4'b0110 rising together in DECODE -> instruction completes; then FETCH→IRQ, irq_id=1, irq_ack=0010; next FETCH -> no IRQ entry (int_en=0); RFE -> pc_source=100; next FETCH enters IRQ with irq_id=2.
REQ-034 irq[0] held high for 10 cycles -> exactly one pending set and one ack.
REQ-035 rst asserted in MEM_RD -> outputs 0 with no clock; after release the first clk performs FETCH, and pending stays 0.
